link_ddr_downstream_rx: RTL and testbench
=========================================

Name: link_ddr_downstream_rx

Overview:
Receive end of the DDR source-synchronous link; counterpart of the upstream transmitter with token/credit flow control.
- Accepts per-channel beats (posedge + negedge halves already captured by the pad layer) and reassembles them into CORE_WIDTH words.
- Buffers words in a small FIFO and presents them to the core with a valid/ready handshake.
- Returns credits to the upstream by toggling a token line once per TOKEN_BATCH words the core consumes.

Parameters:
CHANNEL_WIDTH, 8, bits per channel per clock edge
NUM_CHANNELS, 2, number of parallel link channels
CORE_WIDTH, 64, core word width; must be a multiple of BEAT_WIDTH = 2*CHANNEL_WIDTH*NUM_CHANNELS (default 32, so 2 beats per word)
FIFO_DEPTH, 8, receive buffer depth in words; power of 2, at least 2
TOKEN_BATCH, 4, consumed words per token toggle; power of 2, at most FIFO_DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
io_valid_i  in  NUM_CHANNELS  per-channel beat valid
io_data_i  in  NUM_CHANNELS*2*CHANNEL_WIDTH  per-channel beat data; channel c at [c*2*CW +: 2*CW]; low CW bits = posedge half
core_valid_o  out  1  FIFO head valid
core_data_o  out  CORE_WIDTH  FIFO head word
core_ready_i  in  1  core accepts the head this cycle
token_o  out  1  credit token; toggles once per TOKEN_BATCH pops
overflow_o  out  1  sticky: a word completed while the FIFO was full and not popping
chan_err_o  out  1  sticky: io_valid_i bits disagree (some channels set, some clear)

Behaviour:
- Reset values: core_valid_o=0, core_data_o=0, token_o=0, overflow_o=0, chan_err_o=0. Beat index=0, partial word cleared, FIFO empty, pop counter=0.
- Beat acceptance:
  - A beat is accepted when io_valid_i is all-ones.
  - Beat k of a word lands at assembly bits [k*BEAT_WIDTH +: BEAT_WIDTH]; within a beat, channel c is at [c*2*CW +: 2*CW].
  - Beats need not be consecutive; idle cycles are allowed between them.
- Partial valid: if io_valid_i is neither all-zeros nor all-ones, set chan_err_o, discard the beat, and leave the beat index unchanged.
- Word completion:
  - The beat index counts 0..BEATS_PER_WORD-1 and wraps to 0.
  - On the last beat, {beat data, assembled lower beats} is pushed into the FIFO in that same cycle; there is no separate assembly register stage.
- Latency: when the FIFO is empty, last beat accepted in cycle t gives core_valid_o=1 with that word in cycle t+1.
- Core handshake:
  - A pop happens when core_valid_o && core_ready_i.
  - core_data_o is stable while core_valid_o=1 and core_ready_i=0.
  - core_data_o holds its last value when the FIFO is empty.
- FIFO corner cases:
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push while full without a pop: the word is dropped, overflow_o is set (sticky), and FIFO contents are unchanged.
  - Pop while empty: cannot occur, because core_valid_o=0.
- Token:
  - The pop counter (clog2(TOKEN_BATCH) bits) increments on each pop.
  - When it wraps from TOKEN_BATCH-1 to 0, token_o is inverted in the next cycle.
  - With TOKEN_BATCH=1, token_o toggles on every pop.
  - The upstream initial credit equals FIFO_DEPTH words.
- Reset mid-word: the partial word is discarded and the beat index returns to 0. Beats on the first cycle after rst deasserts start a new word.
- Sticky flags clear only on rst.

Optional Feature:
LINK_RX_WORD_CNT_EN:
- Defined: adds output words_rcvd_o (16 bits), a saturating count of words pushed into the FIFO. It resets to 0, holds at 16'hFFFF, and does not count dropped (overflow) words.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package link_ddr_pkg: BEAT_WIDTH and BEATS_PER_WORD as derived constants, plus a beat-index typedef, shared with the upstream transmitter.
- Sub-module link_rx_fifo: synchronous FIFO, width CORE_WIDTH, depth FIFO_DEPTH. Has push/pop, full/empty, and a registered head output.
- Beat assembly, token counter and error flags stay in the top module.

Test Plan:
- Back-to-back word: beats 32'h11223344 then 32'h55667788 on consecutive cycles, core_ready_i=1 -> core_valid_o one cycle after the second beat with 64'h55667788_11223344, popped that cycle.
- Gapped beats: first beat, 3 idle cycles, second beat -> same word assembled; no chan_err_o.
- Backpressure and overflow: core_ready_i=0, send 8 words -> FIFO full, overflow_o=0. A 9th word -> overflow_o=1 and the 9th word is dropped. Then drain 8 words -> they appear in order, the first word unchanged.
- Token: pop 12 words, TOKEN_BATCH=4 -> token_o toggles exactly 3 times, ending at 1.
- Channel error: io_valid_i=2'b01 for one cycle, then a correct word -> chan_err_o=1 (sticky); the word is still assembled correctly.
- Reset mid-word: first beat, assert rst for 1 cycle, then 2 fresh beats -> exactly one word output, built from the fresh beats only; all outputs 0 during rst.

Source files
------------

// File: rtl/link_ddr_pkg.sv
// Shared constants and helpers for the DDR source-synchronous link.
// Used by both the upstream transmitter and the downstream receiver.
// No ports; provides beat-geometry helpers, default derived constants
// and a beat-index typedef for the default geometry.
package link_ddr_pkg;

    localparam int unsigned DEF_CHANNEL_WIDTH = 8;
    localparam int unsigned DEF_NUM_CHANNELS  = 2;
    localparam int unsigned DEF_CORE_WIDTH    = 64;

    // One beat carries both DDR halves of every channel.
    function automatic int unsigned beat_width(int unsigned cw, int unsigned nc);
        return 2 * cw * nc;
    endfunction

    function automatic int unsigned beats_per_word(int unsigned core, int unsigned cw,
                                                   int unsigned nc);
        return core / beat_width(cw, nc);
    endfunction

    // Counter width that stays at least 1 bit when the range collapses to one value.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BEAT_WIDTH     = beat_width(DEF_CHANNEL_WIDTH, DEF_NUM_CHANNELS);
    localparam int unsigned BEATS_PER_WORD = beats_per_word(DEF_CORE_WIDTH, DEF_CHANNEL_WIDTH,
                                                            DEF_NUM_CHANNELS);
    localparam int unsigned BEAT_IDX_W     = idx_width(BEATS_PER_WORD);

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

endpackage

// File: rtl/link_rx_fifo.sv
// Synchronous receive FIFO with a registered head word.
// Ports: clk, rst (sync, active-high), push/push_data write side,
// pop read side, full/empty status, head = current head word.
// head holds its last value once the FIFO drains.
module link_rx_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a push into a full FIFO is allowed alongside it.
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            // Head follows the next surviving word; held when nothing remains.
            if (do_pop) begin
                if (count > (PW+1)'(1)) begin
                    head <= mem[rd_next];
                end else if (do_push) begin
                    head <= push_data;
                end
            end else if (empty && do_push) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/link_ddr_downstream_rx.sv
// Receive end of the DDR source-synchronous link.
// Reassembles per-channel beats into CORE_WIDTH words, buffers them in
// link_rx_fifo and hands them to the core over valid/ready. Credits are
// returned by toggling token_o once per TOKEN_BATCH consumed words.
// Ports: clk, rst (sync, active-high); io_valid_i/io_data_i link side;
// core_valid_o/core_data_o/core_ready_i core side; token_o credit line;
// overflow_o and chan_err_o sticky error flags.
// Optional: define LINK_RX_WORD_CNT_EN to add words_rcvd_o, a saturating
// 16-bit count of words accepted into the FIFO.
module link_ddr_downstream_rx
    import link_ddr_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned CORE_WIDTH    = 64,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned TOKEN_BATCH   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CHANNELS-1:0]               io_valid_i,
    input  logic [NUM_CHANNELS*2*CHANNEL_WIDTH-1:0] io_data_i,
    output logic                                  core_valid_o,
    output logic [CORE_WIDTH-1:0]                 core_data_o,
    input  logic                                  core_ready_i,
    output logic                                  token_o,
    output logic                                  overflow_o,
    output logic                                  chan_err_o
`ifdef LINK_RX_WORD_CNT_EN
    ,
    output logic [15:0]                           words_rcvd_o
`endif
);

    localparam int unsigned BEAT_W = beat_width(CHANNEL_WIDTH, NUM_CHANNELS);
    localparam int unsigned BPW    = beats_per_word(CORE_WIDTH, CHANNEL_WIDTH, NUM_CHANNELS);
    localparam int unsigned BIDX_W = idx_width(BPW);
    localparam int unsigned PCNT_W = idx_width(TOKEN_BATCH);

    logic [BIDX_W-1:0]     beat_q;
    logic [CORE_WIDTH-1:0] asm_q;
    logic [CORE_WIDTH-1:0] word;
    logic [PCNT_W-1:0]     pcnt_q;
    logic                  token_q;
    logic                  overflow_q;
    logic                  chan_err_q;
    logic                  beat_ok;
    logic                  beat_partial;
    logic                  last_beat;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign beat_ok      = &io_valid_i;
    assign beat_partial = |io_valid_i && !beat_ok;
    assign last_beat    = (beat_q == BIDX_W'(BPW - 1));
    assign push         = beat_ok && last_beat;
    assign pop          = core_valid_o && core_ready_i;
    assign core_valid_o = !empty;

    // Current beat dropped into its slot over the previously assembled beats.
    always_comb begin
        word = asm_q;
        word[int'(beat_q) * BEAT_W +: BEAT_W] = io_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            asm_q  <= '0;
        end else if (beat_ok) begin
            if (last_beat) begin
                beat_q <= '0;
                asm_q  <= '0;
            end else begin
                beat_q <= beat_q + 1'b1;
                asm_q  <= word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= '0;
            token_q <= 1'b0;
        end else if (pop) begin
            if (pcnt_q == PCNT_W'(TOKEN_BATCH - 1)) begin
                pcnt_q  <= '0;
                token_q <= !token_q;
            end else begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            chan_err_q <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (beat_partial) begin
                chan_err_q <= 1'b1;
            end
        end
    end

    assign token_o    = token_q;
    assign overflow_o = overflow_q;
    assign chan_err_o = chan_err_q;

`ifdef LINK_RX_WORD_CNT_EN
    logic [15:0] wcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else if (push && (!full || pop) && (wcnt_q != 16'hFFFF)) begin
            wcnt_q <= wcnt_q + 16'd1;
        end
    end

    assign words_rcvd_o = wcnt_q;
`endif

    link_rx_fifo #(
        .WIDTH (CORE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (core_data_o)
    );

endmodule

// File: tb/tb_link_ddr_downstream_rx.sv
// Directed testbench for link_ddr_downstream_rx with a queue-based model.
module tb_link_ddr_downstream_rx;

    localparam int DEPTH = 8;
    localparam int TB    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  io_valid_i;
    logic [31:0] io_data_i;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_ready_i;
    logic        token_o;
    logic        overflow_o;
    logic        chan_err_o;
`ifdef LINK_RX_WORD_CNT_EN
    logic [15:0] words_rcvd_o;
`endif

    always #5 clk = ~clk;

    link_ddr_downstream_rx dut (
        .clk          (clk),
        .rst          (rst),
        .io_valid_i   (io_valid_i),
        .io_data_i    (io_data_i),
        .core_valid_o (core_valid_o),
        .core_data_o  (core_data_o),
        .core_ready_i (core_ready_i),
        .token_o      (token_o),
        .overflow_o   (overflow_o),
        .chan_err_o   (chan_err_o)
`ifdef LINK_RX_WORD_CNT_EN
        ,
        .words_rcvd_o (words_rcvd_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: words as queue entries, beats as a plain counter.
    logic [63:0] mq[$];
    int          m_beat;
    logic [63:0] m_part;
    logic [63:0] m_head;
    logic        m_tok, m_ovf, m_cerr;
    int          m_pcnt;
    int          m_wcnt;
    bit          chk_en = 0;

    always @(posedge clk) begin
        bit          mpop;
        bit          mdone;
        logic [63:0] w;
        mdone = 0;
        w     = '0;
        if (rst) begin
            mq.delete();
            m_beat = 0; m_part = '0; m_head = '0;
            m_tok = 0; m_ovf = 0; m_cerr = 0; m_pcnt = 0; m_wcnt = 0;
        end else begin
            mpop = (mq.size() > 0) && core_ready_i;
            if (io_valid_i == 2'b11) begin
                m_part[m_beat*32 +: 32] = io_data_i;
                if (m_beat == 1) begin
                    mdone = 1; w = m_part; m_beat = 0; m_part = '0;
                end else begin
                    m_beat++;
                end
            end else if (io_valid_i != 2'b00) begin
                m_cerr = 1;
            end
            if (mpop) begin
                void'(mq.pop_front());
                m_pcnt++;
                if (m_pcnt == TB) begin
                    m_pcnt = 0;
                    m_tok  = ~m_tok;
                end
            end
            if (mdone) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(w);
                    if (m_wcnt < 65535) m_wcnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (mq.size() > 0) m_head = mq[0];
        end
    end

    // Per-cycle compare plus observers for toggles and pops.
    int          tok_toggles = 0;
    logic        tok_prev = 1'b0;
    int          pops_seen = 0;
    logic [63:0] last_pop = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {63'b0, core_valid_o}, {63'b0, mq.size() > 0});
            chk("data", core_data_o, m_head);
            chk("token", {63'b0, token_o}, {63'b0, m_tok});
            chk("overflow", {63'b0, overflow_o}, {63'b0, m_ovf});
            chk("chan_err", {63'b0, chan_err_o}, {63'b0, m_cerr});
`ifdef LINK_RX_WORD_CNT_EN
            chk("words_rcvd", {48'b0, words_rcvd_o}, 64'(m_wcnt));
`endif
            if (token_o != tok_prev) tok_toggles++;
            tok_prev = token_o;
            if (core_valid_o && core_ready_i) begin
                pops_seen++;
                last_pop = core_data_o;
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [31:0] d);
        io_valid_i = v;
        io_data_i  = d;
        @(posedge clk); #1;
        io_valid_i = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input int i);
        drive(2'b11, 32'hA000_0000 | 32'(i));
        drive(2'b11, 32'hB000_0000 | 32'(i));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {63'b0, core_valid_o}, 64'd0);
        chk({tag, "_data"}, core_data_o, 64'd0);
        chk({tag, "_token"}, {63'b0, token_o}, 64'd0);
        chk({tag, "_ovf"}, {63'b0, overflow_o}, 64'd0);
        chk({tag, "_cerr"}, {63'b0, chan_err_o}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; io_valid_i = 2'b00; io_data_i = '0; core_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Back-to-back beats, word visible one cycle after the last beat.
        core_ready_i = 1'b1;
        drive(2'b11, 32'h11223344);
        drive(2'b11, 32'h55667788);
        chk("b2b_valid", {63'b0, core_valid_o}, 64'd1);
        chk("b2b_data", core_data_o, 64'h55667788_11223344);
        idle(2);
        chk("b2b_popped", {63'b0, core_valid_o}, 64'd0);

        // Gapped beats.
        drive(2'b11, 32'hCAFEF00D);
        idle(3);
        drive(2'b11, 32'hDEADBEEF);
        chk("gap_data", core_data_o, 64'hDEADBEEF_CAFEF00D);
        chk("gap_cerr", {63'b0, chan_err_o}, 64'd0);
        idle(2);

        // Partial valid is discarded, flag sticks, next word intact.
        drive(2'b01, 32'h0BAD0BAD);
        drive(2'b11, 32'h01020304);
        drive(2'b11, 32'h05060708);
        chk("cerr_data", core_data_o, 64'h05060708_01020304);
        chk("cerr_flag", {63'b0, chan_err_o}, 64'd1);
        idle(3);
        chk("cerr_sticky", {63'b0, chan_err_o}, 64'd1);

        // Reset in the middle of a word.
        drive(2'b11, 32'h11111111);
        rst = 1'b1;
        idle(1);
        chk_all_zero("midrst");
        rst = 1'b0;
        pops_seen = 0;
        drive(2'b11, 32'h22222222);
        drive(2'b11, 32'h33333333);
        idle(3);
        chk("midrst_words", 64'(pops_seen), 64'd1);
        chk("midrst_word", last_pop, 64'h33333333_22222222);

        // Backpressure, fill, overflow, drain.
        core_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_word(i);
        chk("full_ovf", {63'b0, overflow_o}, 64'd0);
        chk("full_head", core_data_o, 64'hB0000000_A0000000);
        send_word(8);
        idle(1);
        chk("ovf_set", {63'b0, overflow_o}, 64'd1);
        chk("ovf_head", core_data_o, 64'hB0000000_A0000000);
        pops_seen = 0;
        core_ready_i = 1'b1;
        for (int k = 0; k < 40 && pops_seen < DEPTH; k++) idle(1);
        chk("drain_count", 64'(pops_seen), 64'(DEPTH));
        chk("drain_last", last_pop, 64'hB0000007_A0000007);
        idle(2);
        chk("drain_empty", {63'b0, core_valid_o}, 64'd0);
        chk("ovf_sticky", {63'b0, overflow_o}, 64'd1);

        // Token: 12 pops toggle the credit line three times.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        tok_toggles = 0;
        pops_seen = 0;
        for (int i = 0; i < 12; i++) begin
            send_word(16 + i);
            idle(1);
        end
        idle(3);
        chk("tok_pops", 64'(pops_seen), 64'd12);
        chk("tok_toggles", 64'(tok_toggles), 64'd3);
        chk("tok_final", {63'b0, token_o}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
